uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 72 +++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-host handshake bundle for the UART receive FIFO.
// The master side is the receiver and host; the slave side is the FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned DBITS  = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              rxDone;
  logic [DBITS-1:0]  rxData;
  logic              rdValid;
  logic [DBITS-1:0]  rdData;
  logic              rdReady;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              ovrClr;
  logic              rtsN;

  modport master (
    output rxDone, rxData, rdReady, ovrClr,
    input  rdValid, rdData, full, empty, count, overrun, rtsN
  );

  modport slave (
    input  rxDone, rxData, rdReady, ovrClr,
    output rdValid, rdData, full, empty, count, overrun, rtsN
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular FWFT receive FIFO behind the UART receiver, with sticky overrun
// and an almost-full RTS flow-control output.
module uart_rx_fifo #(
  parameter int unsigned DBITS    = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic          clk,
  input  logic          resetn,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PW    = ADDR_W + 1;

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_overrun;
  logic             r_rts_n;

  logic [PW-1:0]    w_count;
  logic [PW-1:0]    w_count_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // Pointer MSB distinguishes a full ring from an empty one.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_count = r_wr_ptr - r_rd_ptr;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_pop   = !w_empty && bus.rdReady;
  assign w_push  = bus.rxDone && (!w_full || w_pop);
  assign w_drop  = bus.rxDone && w_full && !w_pop;

  assign w_count_nxt = w_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
      r_rts_n   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)          r_overrun <= 1'b1;
      else if (bus.ovrClr) r_overrun <= 1'b0;
      r_rts_n <= (32'(w_count_nxt) >= AF_LEVEL);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.rxData;
  end

  assign bus.rdData  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign bus.rdValid = !w_empty;
  assign bus.full    = w_full;
  assign bus.empty   = w_empty;
  assign bus.count   = w_count;
  assign bus.overrun = r_overrun;
  assign bus.rtsN    = r_rts_n;

endmodule
